// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the convolution input sequencer.
// NOUT is derived so the window count follows any DEPTH/KSIZE/STRIDE change.
package conv_pkg;
   localparam int DW     = 16;
   localparam int AW     = 5;
   localparam int DEPTH  = 19;
   localparam int KSIZE  = 3;
   localparam int STRIDE = 1;
   localparam int NOUT   = (DEPTH - KSIZE) / STRIDE + 1;
   localparam int TW     = (KSIZE > 1) ? $clog2(KSIZE) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CONV = 2'd2
   } state_t;
endpackage

// File: rtl/conv_win_addr_gen.sv
// Window/tap counters for replay: produces the RAM read address, tap flags
// and whether any taps remain in the frame.
module conv_win_addr_gen
   import conv_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clear,
   input  logic          i_issue,
   output logic [AW-1:0] o_raddr,
   output logic [AW-1:0] o_pos,
   output logic          o_first,
   output logic          o_last,
   output logic          o_more
);
   logic [AW-1:0] r_pos;
   logic [TW-1:0] r_tap;
   logic          w_tap_end;

   assign w_tap_end = (r_tap == TW'(KSIZE - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pos <= '0;
         r_tap <= '0;
      end else if (i_clear) begin
         r_pos <= '0;
         r_tap <= '0;
      end else if (i_issue) begin
         if (w_tap_end) begin
            r_tap <= '0;
            r_pos <= r_pos + AW'(1);
         end else begin
            r_tap <= r_tap + TW'(1);
         end
      end
   end

   assign o_raddr = AW'(int'(r_pos) * STRIDE + int'(r_tap));
   assign o_pos   = r_pos;
   assign o_first = (r_tap == '0);
   assign o_last  = w_tap_end;
   // r_pos reaching NOUT marks the frame as fully issued
   assign o_more  = (r_pos < AW'(NOUT));
endmodule

// File: rtl/conv_input_sequencer.sv
// Loads one frame into the input sample RAM, then replays it as sliding
// windows to the MAC, absorbing the RAM's one-cycle read latency.
//
// state | meaning
// IDLE  | waiting for start, all counters cleared
// LOAD  | accepting DEPTH samples from upstream into the RAM
// CONV  | issuing window taps to the MAC until the last one is accepted
module conv_input_sequencer
   import conv_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          ram_we,
   output logic [AW-1:0] ram_waddr,
   output logic [DW-1:0] ram_wdata,
   output logic          ram_re,
   output logic [AW-1:0] ram_raddr,
   input  logic [DW-1:0] ram_rdata,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          out_first,
   output logic          out_last,
   output logic [AW-1:0] out_pos,
   input  logic          out_ready,
   output logic          busy,
   output logic          done
);
   state_t        r_state;
   logic [AW-1:0] r_wcnt;
   logic          r_out_valid;
   logic          r_out_first;
   logic          r_out_last;
   logic [AW-1:0] r_out_pos;
   logic          r_done;

   logic          w_in_ready;
   logic          w_we;
   logic          w_issue;
   logic          w_accept;
   logic          w_final;
   logic          w_load_end;
   logic [AW-1:0] w_raddr;
   logic [AW-1:0] w_pos;
   logic          w_first;
   logic          w_last;
   logic          w_more;

   assign w_in_ready = (r_state == LOAD);
   assign w_we       = in_valid & w_in_ready;
   assign w_load_end = w_we & (r_wcnt == AW'(DEPTH - 1));
   // Output slot is free when empty or being drained this cycle
   assign w_issue    = (r_state == CONV) & w_more & (~r_out_valid | out_ready);
   assign w_accept   = r_out_valid & out_ready;
   assign w_final    = w_accept & r_out_last & (r_out_pos == AW'(NOUT - 1));

   conv_win_addr_gen u_addr_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (r_state == IDLE),
      .i_issue (w_issue),
      .o_raddr (w_raddr),
      .o_pos   (w_pos),
      .o_first (w_first),
      .o_last  (w_last),
      .o_more  (w_more)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE:    if (start) r_state <= LOAD;
            LOAD:    if (w_load_end) r_state <= CONV;
            CONV:    if (w_final) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wcnt <= '0;
      end else if (r_state == IDLE) begin
         r_wcnt <= '0;
      end else if (w_we) begin
         r_wcnt <= r_wcnt + AW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_first <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_pos   <= '0;
      end else if (w_issue) begin
         r_out_valid <= 1'b1;
         r_out_first <= w_first;
         r_out_last  <= w_last;
         r_out_pos   <= w_pos;
      end else if (w_accept) begin
         r_out_valid <= 1'b0;
         r_out_first <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_pos   <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_done <= 1'b0;
      else        r_done <= w_final;
   end

   assign in_ready  = w_in_ready;
   assign ram_we    = w_we;
   assign ram_waddr = r_wcnt;
   assign ram_wdata = in_data;
   assign ram_re    = w_issue;
   assign ram_raddr = w_raddr;
   assign out_valid = r_out_valid;
   assign out_data  = ram_rdata;
   assign out_first = r_out_first;
   assign out_last  = r_out_last;
   assign out_pos   = r_out_pos;
   assign busy      = (r_state != IDLE);
   assign done      = r_done;
endmodule
